// File: rtl/fifo_state_cal_if.sv
// Interface between the FIFO next-state logic and its registered
// state/datapath stage: the next-state request plus write data going in,
// and the registered state, pointers, read data and status flags coming out.
interface fifo_state_cal_if #(
  parameter int DATA_WIDTH = 32
);
  logic [2:0]            next_state;
  logic [DATA_WIDTH-1:0] din;
  logic [2:0]            state;
  logic [3:0]            data_count;
  logic [2:0]            head;
  logic [2:0]            tail;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;

  // Next-state logic / FIFO user side
  modport master (
    output next_state, din,
    input  state, data_count, head, tail, dout, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err
  );

  // Registered state and datapath stage
  modport slave (
    input  next_state, din,
    output state, data_count, head, tail, dout, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err
  );
endinterface

// File: rtl/fifo_state_cal.sv
// Registered state-and-datapath stage of an 8-entry FIFO. Registers the
// requested next state, performs the write/read/error action it encodes,
// and keeps head, tail, data_count and the storage array consistent.
module fifo_state_cal #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic              clk,
  input  logic              reset,
  fifo_state_cal_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_WRITE    = 3'b001,
    ST_READ     = 3'b010,
    ST_WR_ERROR = 3'b011,
    ST_RD_ERROR = 3'b100
  } state_t;

  localparam logic [3:0] FULL_COUNT = 4'(DEPTH);

  state_t                state_reg, state_next;
  logic [2:0]            head_reg, head_next;
  logic [2:0]            tail_reg, tail_next;
  logic [3:0]            count_reg, count_next;
  logic                  wr_ack_reg, wr_ack_next;
  logic                  wr_err_reg, wr_err_next;
  logic                  rd_ack_reg, rd_ack_next;
  logic                  rd_err_reg, rd_err_next;
  logic                  do_write;
  logic                  do_read;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Decode the requested state (unknown codes collapse to IDLE) and work out
  // the action it implies, guarding writes when full and reads when empty.
  always_comb begin
    state_next  = ST_IDLE;
    head_next   = head_reg;
    tail_next   = tail_reg;
    count_next  = count_reg;
    wr_ack_next = 1'b0;
    wr_err_next = 1'b0;
    rd_ack_next = 1'b0;
    rd_err_next = 1'b0;
    do_write    = 1'b0;
    do_read     = 1'b0;

    case (bus.next_state)
      3'b000:  state_next = ST_IDLE;
      3'b001:  state_next = ST_WRITE;
      3'b010:  state_next = ST_READ;
      3'b011:  state_next = ST_WR_ERROR;
      3'b100:  state_next = ST_RD_ERROR;
      default: state_next = ST_IDLE;
    endcase

    case (state_next)
      ST_WRITE: begin
        if (count_reg == FULL_COUNT) begin
          wr_err_next = 1'b1;
        end else begin
          do_write    = 1'b1;
          tail_next   = tail_reg + 3'd1;
          count_next  = count_reg + 4'd1;
          wr_ack_next = 1'b1;
        end
      end
      ST_READ: begin
        if (count_reg == 4'd0) begin
          rd_err_next = 1'b1;
        end else begin
          do_read     = 1'b1;
          head_next   = head_reg + 3'd1;
          count_next  = count_reg - 4'd1;
          rd_ack_next = 1'b1;
        end
      end
      ST_WR_ERROR: wr_err_next = 1'b1;
      ST_RD_ERROR: rd_err_next = 1'b1;
      default: ;
    endcase
  end

  // State, pointer, count and status-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      head_reg   <= 3'd0;
      tail_reg   <= 3'd0;
      count_reg  <= 4'd0;
      wr_ack_reg <= 1'b0;
      wr_err_reg <= 1'b0;
      rd_ack_reg <= 1'b0;
      rd_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      head_reg   <= head_next;
      tail_reg   <= tail_next;
      count_reg  <= count_next;
      wr_ack_reg <= wr_ack_next;
      wr_err_reg <= wr_err_next;
      rd_ack_reg <= rd_ack_next;
      rd_err_reg <= rd_err_next;
    end
  end

  // Storage write port; contents are left alone by reset.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[tail_reg] <= bus.din;
    end
  end

  // Registered read port; dout holds until the next successful read.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_reg <= '0;
    end else if (do_read) begin
      dout_reg <= mem[head_reg];
    end
  end

  assign bus.state      = state_reg;
  assign bus.head       = head_reg;
  assign bus.tail       = tail_reg;
  assign bus.data_count = count_reg;
  assign bus.dout       = dout_reg;
  assign bus.full       = (count_reg == FULL_COUNT);
  assign bus.empty      = (count_reg == 4'd0);
  assign bus.wr_ack     = wr_ack_reg;
  assign bus.wr_err     = wr_err_reg;
  assign bus.rd_ack     = rd_ack_reg;
  assign bus.rd_err     = rd_err_reg;

endmodule

// File: tb/tb_fifo_state_cal.sv
// Scoreboard bench for fifo_state_cal: each directed step drives next_state
// and din before a rising edge and queues the hand-computed outputs expected
// in the following cycle; a monitor pops and compares after every edge.
module tb_fifo_state_cal;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   step_no;

  fifo_state_cal_if #(.DATA_WIDTH(32)) bus ();

  fifo_state_cal #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse encoding: {wr_ack, wr_err, rd_ack, rd_err}
  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_WA   = 4'b1000;
  localparam logic [3:0] P_WE   = 4'b0100;
  localparam logic [3:0] P_RA   = 4'b0010;
  localparam logic [3:0] P_RE   = 4'b0001;

  typedef struct {
    int          idx;
    logic [2:0]  st;
    logic [3:0]  cnt;
    logic [2:0]  hd;
    logic [2:0]  tl;
    logic [31:0] dt;
    logic [3:0]  pl;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input int idx, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
    end
  endtask

  // Monitor: compare outputs one cycle after each stimulus edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.idx, "state", 32'(bus.state), 32'(e.st));
        chk(e.idx, "count", 32'(bus.data_count), 32'(e.cnt));
        chk(e.idx, "head", 32'(bus.head), 32'(e.hd));
        chk(e.idx, "tail", 32'(bus.tail), 32'(e.tl));
        chk(e.idx, "dout", bus.dout, e.dt);
        chk(e.idx, "full", 32'(bus.full), 32'(e.cnt == 4'd8));
        chk(e.idx, "empty", 32'(bus.empty), 32'(e.cnt == 4'd0));
        chk(e.idx, "pulses", 32'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}),
            32'(e.pl));
        $display("step %0d: ns_result state=%0d count=%0d head=%0d tail=%0d dout=0x%0h",
                 e.idx, bus.state, bus.data_count, bus.head, bus.tail, bus.dout);
      end
    end
  end

  task automatic step(input logic r, input logic [2:0] ns, input logic [31:0] d,
                      input logic [2:0] es, input int ec, input int eh, input int et,
                      input logic [31:0] ed, input logic [3:0] ep);
    exp_t e;
    @(negedge clk);
    reset          = r;
    bus.next_state = ns;
    bus.din        = d;
    step_no++;
    e.idx = step_no;
    e.st  = es;
    e.cnt = 4'(ec);
    e.hd  = 3'(eh);
    e.tl  = 3'(et);
    e.dt  = ed;
    e.pl  = ep;
    exp_q.push_back(e);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    step_no        = 0;
    reset          = 1'b1;
    bus.next_state = 3'b000;
    bus.din        = '0;

    // Reset held two cycles while a WRITE is requested
    step(1, 3'b001, 32'hAAAA_AAAA, 3'b000, 0, 0, 0, 32'h0, P_NONE);
    step(1, 3'b001, 32'hAAAA_AAAA, 3'b000, 0, 0, 0, 32'h0, P_NONE);

    // Fill with 0x10..0x17, then overflow
    for (int i = 0; i < 8; i++)
      step(0, 3'b001, 32'h10 + i, 3'b001, i + 1, 0, (i + 1) % 8, 32'h0, P_WA);
    step(0, 3'b011, 32'h0, 3'b011, 8, 0, 0, 32'h0, P_WE);
    step(0, 3'b001, 32'hDEAD, 3'b001, 8, 0, 0, 32'h0, P_WE);

    // Drain in order, then underflow
    for (int i = 0; i < 8; i++)
      step(0, 3'b010, 32'h0, 3'b010, 7 - i, (i + 1) % 8, 0, 32'h10 + i, P_RA);
    step(0, 3'b100, 32'h0, 3'b100, 0, 0, 0, 32'h17, P_RE);
    step(0, 3'b010, 32'h0, 3'b010, 0, 0, 0, 32'h17, P_RE);
    step(0, 3'b000, 32'h0, 3'b000, 0, 0, 0, 32'h17, P_NONE);

    // Wrap-around: write 6, read 6, write 4, read 4
    for (int i = 0; i < 6; i++)
      step(0, 3'b001, 32'h20 + i, 3'b001, i + 1, 0, i + 1, 32'h17, P_WA);
    for (int i = 0; i < 6; i++)
      step(0, 3'b010, 32'h0, 3'b010, 5 - i, i + 1, 6, 32'h20 + i, P_RA);
    step(0, 3'b001, 32'hA0, 3'b001, 1, 6, 7, 32'h25, P_WA);
    step(0, 3'b001, 32'hA1, 3'b001, 2, 6, 0, 32'h25, P_WA);
    step(0, 3'b001, 32'hA2, 3'b001, 3, 6, 1, 32'h25, P_WA);
    step(0, 3'b001, 32'hA3, 3'b001, 4, 6, 2, 32'h25, P_WA);
    step(0, 3'b010, 32'h0, 3'b010, 3, 7, 2, 32'hA0, P_RA);
    step(0, 3'b010, 32'h0, 3'b010, 2, 0, 2, 32'hA1, P_RA);
    step(0, 3'b010, 32'h0, 3'b010, 1, 1, 2, 32'hA2, P_RA);
    step(0, 3'b010, 32'h0, 3'b010, 0, 2, 2, 32'hA3, P_RA);

    // Illegal next_state codes with count=3
    step(0, 3'b001, 32'h30, 3'b001, 1, 2, 3, 32'hA3, P_WA);
    step(0, 3'b001, 32'h31, 3'b001, 2, 2, 4, 32'hA3, P_WA);
    step(0, 3'b001, 32'h32, 3'b001, 3, 2, 5, 32'hA3, P_WA);
    step(0, 3'b111, 32'hBAD0, 3'b000, 3, 2, 5, 32'hA3, P_NONE);
    step(0, 3'b101, 32'hBAD1, 3'b000, 3, 2, 5, 32'hA3, P_NONE);
    step(0, 3'b110, 32'hBAD2, 3'b000, 3, 2, 5, 32'hA3, P_NONE);
    step(0, 3'b010, 32'h0, 3'b010, 2, 3, 5, 32'h30, P_RA);

    // Reset during the 4th of a WRITE burst
    step(0, 3'b001, 32'h40, 3'b001, 3, 3, 6, 32'h30, P_WA);
    step(0, 3'b001, 32'h41, 3'b001, 4, 3, 7, 32'h30, P_WA);
    step(0, 3'b001, 32'h42, 3'b001, 5, 3, 0, 32'h30, P_WA);
    step(1, 3'b001, 32'h43, 3'b000, 0, 0, 0, 32'h0, P_NONE);
    step(0, 3'b001, 32'h55, 3'b001, 1, 0, 1, 32'h0, P_WA);
    step(0, 3'b010, 32'h0, 3'b010, 0, 1, 1, 32'h55, P_RA);
    step(0, 3'b000, 32'h0, 3'b000, 0, 1, 1, 32'h55, P_NONE);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
